// File: rtl/w4823_fir_pkg.sv
// Shared FIR coefficient-path constants and the coefficient-loader state encoding.
package w4823_fir_pkg;

    localparam int unsigned NTAPS = 64;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MIRROR = 3'd2,
        ST_FIN    = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

endpackage

// File: rtl/w4823_fir_coef_loader.sv
// Streams a burst of FP16 coefficients into the FIR tap store over cin/caddr/cload,
// optionally duplicating each write to its mirror tap for linear-phase filters.
module w4823_fir_coef_loader
    import w4823_fir_pkg::*;
(
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   count,
    input  logic          sym,
    input  logic          abort,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] cin,
    output logic [AW-1:0] caddr,
    output logic          cload,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state, state_d;
    logic [AW-1:0] addr, addr_d;
    logic [AW:0]   rem, rem_d;
    logic          sym_q, sym_d;
    logic [DW-1:0] cin_d;
    logic [AW-1:0] caddr_d;
    logic          cload_d, busy_d, done_d, err_d;
    logic [AW+1:0] span, limit;
    logic          legal, accept;

    // Command must fit entirely inside the store (half of it when mirrored).
    assign span   = (AW+2)'(base) + (AW+2)'(count);
    assign limit  = sym ? (AW+2)'(NTAPS / 2) : (AW+2)'(NTAPS);
    assign legal  = (count != '0) && (count <= (AW+1)'(NTAPS)) && (span <= limit);

    assign s_ready = (state == ST_LOAD) && !abort;
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        addr_d  = addr;
        rem_d   = rem;
        sym_d   = sym_q;
        cin_d   = cin;
        caddr_d = caddr;
        cload_d = 1'b0;
        err_d   = err;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_d = ST_LOAD;
                        addr_d  = base;
                        rem_d   = count;
                        sym_d   = sym;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    cload_d = 1'b1;
                    caddr_d = addr;
                    cin_d   = s_data;
                    addr_d  = addr + AW'(1);
                    rem_d   = rem - (AW+1)'(1);
                    if (sym_q) begin
                        state_d = ST_MIRROR;
                    end else if (rem == (AW+1)'(1)) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_MIRROR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    // Mirror tap reuses the coefficient still held on cin.
                    cload_d = 1'b1;
                    caddr_d = AW'(NTAPS - 1) - caddr;
                    state_d = (rem == '0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_MIRROR) || (state_d == ST_FIN);
        done_d = (state == ST_FIN) || (state_d == ST_ERR);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            rem   <= '0;
            sym_q <= 1'b0;
            cin   <= '0;
            caddr <= '0;
            cload <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            addr  <= addr_d;
            rem   <= rem_d;
            sym_q <= sym_d;
            cin   <= cin_d;
            caddr <= caddr_d;
            cload <= cload_d;
            busy  <= busy_d;
            done  <= done_d;
            err   <= err_d;
        end
    end

endmodule

// File: tb/tb_w4823_fir_coef_loader.sv
// Directed bench for the FIR coefficient loader: write log checked against hand-built expectations.
module tb_w4823_fir_coef_loader;

    logic        clk1, rst_n, start, sym, abort, s_valid, s_ready;
    logic [5:0]  base, caddr;
    logic [6:0]  count;
    logic [15:0] s_data, cin;
    logic        cload, busy, done, err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [5:0]  wa[$];
    logic [15:0] wd[$];
    int          wcyc[$];
    int          acc_cyc[$];
    logic [5:0]  ea[$];
    logic [15:0] ed[$];
    int it, rd, d0;

    w4823_fir_coef_loader dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .base(base), .count(count),
        .sym(sym), .abort(abort), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cin(cin), .caddr(caddr), .cload(cload), .busy(busy), .done(done), .err(err)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    always @(posedge clk1) cyc <= cyc + 1;

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clk1) begin
        if (cload) begin
            wa.push_back(caddr);
            wd.push_back(cin);
            wcyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wcyc.delete(); acc_cyc.delete();
        ea.delete(); ed.delete();
    endtask

    task automatic do_start(input logic [5:0] b, input logic [6:0] c, input logic s);
        @(negedge clk1);
        start = 1'b1; base = b; count = c; sym = s;
        @(negedge clk1);
        start = 1'b0; base = 6'h3f; count = 7'h7f; sym = ~s;
    endtask

    // Offer n beats with valid on every period-th cycle; returns cycles spent and ready cycles seen.
    task automatic feed(input int n, input logic [15:0] dbase, input int period,
                        output int iters, output int rdys);
        int k = 0;
        iters = 0;
        rdys  = 0;
        while (k < n && iters < 400) begin
            s_valid = (iters % period == 0);
            s_data  = dbase + 16'(k);
            #1;
            if (s_ready) rdys++;
            if (s_valid && s_ready) begin
                acc_cyc.push_back(cyc + 1);
                k++;
            end
            iters++;
            @(negedge clk1);
        end
        s_valid = 1'b0;
        chk("feed_beats", k, n);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int dstart = done_cnt;
        int i = 0;
        while (done_cnt == dstart && i < budget) begin
            @(negedge clk1);
            #1;
            i++;
        end
        chk({tag, "_done_seen"}, done_cnt - dstart, 1);
    endtask

    task automatic check_log(input string tag, input int contiguous);
        int bad = 0;
        int n;
        chk({tag, "_nwrites"}, wa.size(), ea.size());
        n = (wa.size() < ea.size()) ? wa.size() : ea.size();
        for (int j = 0; j < n; j++)
            if (wa[j] !== ea[j] || wd[j] !== ed[j]) bad++;
        chk({tag, "_writes"}, bad, 0);
        if (contiguous != 0 && wa.size() > 0) begin
            chk({tag, "_contig"}, wcyc[wcyc.size()-1] - wcyc[0], wa.size() - 1);
            chk({tag, "_done_cyc"}, done_cyc, wcyc[wcyc.size()-1] + 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; s_valid = 1'b1; s_data = 16'hffff;
        base = 6'd0; count = 7'd8; sym = 1'b0; abort = 1'b0;

        // Reset with start/valid asserted, then release and watch for stray writes.
        repeat (3) @(negedge clk1);
        #1;
        chk("rst_cin", cin, 0);
        chk("rst_caddr", caddr, 0);
        chk("rst_cload", cload, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk1);
        rst_n = 1'b1; start = 1'b0;
        repeat (5) @(negedge clk1);
        #1;
        chk("rst_no_cload", wa.size(), 0);
        chk("rst_busy_after", busy, 0);
        s_valid = 1'b0;

        // Full 64-tap load, valid held.
        clear_log();
        for (int i = 0; i < 64; i++) begin
            ea.push_back(6'(i)); ed.push_back(16'h3C00 + 16'(i));
        end
        do_start(6'd0, 7'd64, 1'b0);
        #1;
        chk("full_busy", busy, 1);
        feed(64, 16'h3C00, 1, it, rd);
        wait_done("full", 20);
        check_log("full", 1);
        chk("full_err", err, 0);
        chk("full_busy_end", busy, 0);

        // Symmetric 32-beat load: pairs (i, 63-i).
        clear_log();
        for (int i = 0; i < 32; i++) begin
            ea.push_back(6'(i));      ed.push_back(16'h4000 + 16'(i));
            ea.push_back(6'(63 - i)); ed.push_back(16'h4000 + 16'(i));
        end
        do_start(6'd0, 7'd32, 1'b1);
        feed(32, 16'h4000, 1, it, rd);
        chk("sym_ready_cycles", rd, 32);
        chk("sym_total_cycles", it, 63);
        wait_done("sym", 20);
        check_log("sym", 1);

        // Backpressure: valid 1,0,0 pattern.
        clear_log();
        for (int i = 0; i < 4; i++) begin
            ea.push_back(6'(10 + i)); ed.push_back(16'h5000 + 16'(i));
        end
        do_start(6'd10, 7'd4, 1'b0);
        feed(4, 16'h5000, 3, it, rd);
        wait_done("bp", 20);
        check_log("bp", 0);
        d0 = 0;
        for (int j = 0; j < acc_cyc.size() && j < wcyc.size(); j++)
            if (wcyc[j] != acc_cyc[j]) d0++;
        chk("bp_latency", d0, 0);

        // Illegal commands: err + done the cycle after start, no writes.
        clear_log();
        do_start(6'd0, 7'd0, 1'b0);
        #1;
        chk("err0_err", err, 1);
        chk("err0_done", done, 1);
        @(negedge clk1);
        #1;
        chk("err0_done_pulse", done, 0);
        chk("err0_err_hold", err, 1);
        do_start(6'd60, 7'd5, 1'b0);
        #1;
        chk("err1_err", err, 1);
        chk("err1_done", done, 1);
        do_start(6'd20, 7'd20, 1'b1);
        #1;
        chk("err2_err", err, 1);
        chk("err2_done", done, 1);
        chk("err2_busy", busy, 0);
        repeat (3) @(negedge clk1);
        chk("err_no_writes", wa.size(), 0);

        // Legal start clears err.
        ea.push_back(6'd5); ed.push_back(16'h1234);
        do_start(6'd5, 7'd1, 1'b0);
        #1;
        chk("err_cleared", err, 0);
        feed(1, 16'h1234, 1, it, rd);
        wait_done("one", 10);
        check_log("one", 1);

        // Abort after 3 beats of 8.
        clear_log();
        for (int i = 0; i < 3; i++) begin
            ea.push_back(6'(i)); ed.push_back(16'h6000 + 16'(i));
        end
        d0 = done_cnt;
        do_start(6'd0, 7'd8, 1'b0);
        feed(3, 16'h6000, 1, it, rd);
        abort = 1'b1; s_valid = 1'b1; s_data = 16'hdead;
        #1;
        chk("abort_ready", s_ready, 0);
        @(negedge clk1);
        abort = 1'b0; s_valid = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        repeat (4) @(negedge clk1);
        #1;
        check_log("abort", 0);
        chk("abort_no_done", done_cnt - d0, 0);

        // Reset pulse after 3 beats of 8.
        clear_log();
        for (int i = 0; i < 3; i++) begin
            ea.push_back(6'(i)); ed.push_back(16'h7000 + 16'(i));
        end
        d0 = done_cnt;
        do_start(6'd0, 7'd8, 1'b0);
        feed(3, 16'h7000, 1, it, rd);
        #2;
        rst_n = 1'b0; s_valid = 1'b1;
        #1;
        chk("mrst_cload", cload, 0);
        chk("mrst_caddr", caddr, 0);
        chk("mrst_cin", cin, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ready", s_ready, 0);
        @(negedge clk1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk1);
        #1;
        s_valid = 1'b0;
        check_log("mrst", 0);
        chk("mrst_no_done", done_cnt - d0, 0);
        chk("mrst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
